// File: rtl/order_pkg.sv
// Shared constants, recipe types and colours for the order queue panel.
package order_pkg;
    localparam int NUM_TYPES  = 4;
    localparam int TYPE_W     = $clog2(NUM_TYPES);
    localparam int ORDER_TIME = 30;

    typedef enum logic [TYPE_W-1:0] {
        R_SALAD  = 2'd0,
        R_SOUP   = 2'd1,
        R_BURGER = 2'd2,
        R_PASTA  = 2'd3
    } recipe_e;

    localparam logic [11:0] C_NONE    = 12'h000;
    localparam logic [11:0] C_EMPTY   = 12'h111;
    localparam logic [11:0] C_BAR_BG  = 12'h222;
    localparam logic [11:0] C_BAR_OK  = 12'h0F0;
    localparam logic [11:0] C_BAR_LOW = 12'h700;
    localparam logic [11:0] C_BLINK   = 12'hF00;
endpackage

// File: rtl/order_queue_display_if.sv
// Order event handshake between game logic (master) and the queue (slave).
interface order_queue_display_if #(parameter int NUM_ORDERS = 4);
    import order_pkg::*;

    logic                  new_order_valid;
    logic [TYPE_W-1:0]     new_order_type;
    logic                  order_ready;
    logic                  complete_valid;
    logic [TYPE_W-1:0]     complete_type;
    logic                  complete_hit;
    logic                  complete_miss;
    logic [NUM_ORDERS-1:0] expired_mask;
    logic [NUM_ORDERS-1:0] active_mask;

    modport master (
        output new_order_valid, new_order_type, complete_valid, complete_type,
        input  order_ready, complete_hit, complete_miss, expired_mask, active_mask
    );
    modport slave (
        input  new_order_valid, new_order_type, complete_valid, complete_type,
        output order_ready, complete_hit, complete_miss, expired_mask, active_mask
    );
endinterface

// File: rtl/order_queue_display_slot_bank.sv
// Slot registers: accept into lowest free slot, complete lowest matching slot,
// per-second countdown with expiry; completion wins over a same-cycle expiry.
module order_slot_bank import order_pkg::*; #(
    parameter int NUM_ORDERS     = 4,
    parameter int TIMER_W        = 5,
    parameter int FRAMES_PER_SEC = 60,
    parameter int ORDER_TIME_P   = ORDER_TIME
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              tick,
    order_queue_display_if.slave              ord,
    output recipe_e                           slot_type [NUM_ORDERS],
    output logic [NUM_ORDERS-1:0][TIMER_W-1:0] slot_time,
    output logic                              blink_phase
);
    localparam int PS_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

    logic [NUM_ORDERS-1:0] active, free_sel, hit_sel, expire;
    logic [PS_W-1:0]       presc;
    logic [7:0]            blink;
    logic                  wrap;

    assign wrap            = tick && (presc == PS_W'(FRAMES_PER_SEC - 1));
    assign ord.order_ready = ~&active;
    assign ord.active_mask = active;
    assign blink_phase     = blink[4];

    // Descending scan so the lowest index wins.
    always_comb begin
        free_sel = '0;
        hit_sel  = '0;
        for (int i = NUM_ORDERS - 1; i >= 0; i--) begin
            if (!active[i]) begin
                free_sel    = '0;
                free_sel[i] = 1'b1;
            end
            if (active[i] && slot_type[i] == recipe_e'(ord.complete_type)) begin
                hit_sel    = '0;
                hit_sel[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_ORDERS; i++)
            expire[i] = wrap && active[i] && (slot_time[i] == TIMER_W'(1)) &&
                        !(ord.complete_valid && hit_sel[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active            <= '0;
            slot_time         <= '0;
            presc             <= '0;
            blink             <= '0;
            ord.complete_hit  <= 1'b0;
            ord.complete_miss <= 1'b0;
            ord.expired_mask  <= '0;
            for (int i = 0; i < NUM_ORDERS; i++) slot_type[i] <= R_SALAD;
        end else begin
            if (tick) begin
                presc <= wrap ? '0 : presc + 1'b1;
                blink <= blink + 8'd1;
            end
            ord.complete_hit  <= ord.complete_valid && (|hit_sel);
            ord.complete_miss <= ord.complete_valid && !(|hit_sel);
            ord.expired_mask  <= expire;
            for (int i = 0; i < NUM_ORDERS; i++) begin
                if (ord.complete_valid && hit_sel[i]) begin
                    active[i] <= 1'b0;
                end else if (wrap && active[i]) begin
                    slot_time[i] <= slot_time[i] - 1'b1;
                    if (expire[i]) active[i] <= 1'b0;
                end else if (ord.new_order_valid && free_sel[i]) begin
                    active[i]    <= 1'b1;
                    slot_type[i] <= recipe_e'(ord.new_order_type);
                    slot_time[i] <= TIMER_W'(ORDER_TIME_P);
                end
            end
        end
    end
endmodule

// File: rtl/order_queue_display.sv
// Order queue panel: slot bank plus a fixed-latency render pipeline that
// aligns region flags with the external icon ROM read.
module order_queue_display import order_pkg::*; #(
    parameter int NUM_ORDERS     = 4,
    parameter int ICON_W         = 32,
    parameter int ICON_H         = 32,
    parameter int SLOT_GAP       = 8,
    parameter int BAR_H          = 4,
    parameter int TIMER_W        = 5,
    parameter int FRAMES_PER_SEC = 60,
    parameter int BLINK_THRESH   = 5,
    parameter int ROM_LATENCY    = 2,
    localparam int ROM_AW        = $clog2(NUM_TYPES * ICON_W * ICON_H)
) (
    input  logic               pixel_clk_in,
    input  logic               rst_n_in,
    input  logic [9:0]         x_in,
    input  logic [8:0]         y_in,
    input  logic [9:0]         hcount,
    input  logic [8:0]         vcount,
    order_queue_display_if.slave ord,
    output logic [ROM_AW-1:0]  rom_addr_out,
    input  logic [11:0]        rom_pixel_in,
    output logic [11:0]        pixel_out
);
    localparam int SLOT_W = $clog2(NUM_ORDERS);
    localparam int PITCH  = ICON_W + SLOT_GAP;
    localparam int DX_W   = $clog2(ICON_W);
    localparam int DY_W   = $clog2(ICON_H);

    typedef struct packed {
        logic              icon;
        logic              bar;
        logic [SLOT_W-1:0] slot;
        logic [DX_W-1:0]   dx;
    } rflag_t;

    recipe_e                            slot_type [NUM_ORDERS];
    logic [NUM_ORDERS-1:0][TIMER_W-1:0] slot_time;
    logic                               blink_phase;

    order_slot_bank #(
        .NUM_ORDERS(NUM_ORDERS), .TIMER_W(TIMER_W), .FRAMES_PER_SEC(FRAMES_PER_SEC)
    ) u_bank (
        .clk(pixel_clk_in), .rst_n(rst_n_in),
        .tick(hcount == 10'd0 && vcount == 9'd0),
        .ord(ord), .slot_type(slot_type), .slot_time(slot_time),
        .blink_phase(blink_phase)
    );

    // 11-bit slot bounds so anything past column 1023 never matches.
    logic [NUM_ORDERS-1:0]           x_hit;
    logic [NUM_ORDERS-1:0][DX_W-1:0] dx_all;
    for (genvar i = 0; i < NUM_ORDERS; i++) begin : g_slot
        logic [10:0] x0;
        assign x0        = {1'b0, x_in} + 11'(i * PITCH);
        assign x_hit[i]  = ({1'b0, hcount} >= x0) && ({1'b0, hcount} < x0 + 11'(ICON_W));
        assign dx_all[i] = DX_W'(hcount - x0[9:0]);
    end

    logic              sel_hit, y_ge, icon_row, bar_row;
    logic [SLOT_W-1:0] sel_slot;
    logic [DX_W-1:0]   sel_dx;
    logic [8:0]        ry;

    assign y_ge     = vcount >= y_in;
    assign ry       = vcount - y_in;
    assign icon_row = y_ge && ry < 9'(ICON_H);
    assign bar_row  = y_ge && ry >= 9'(ICON_H) && ry < 9'(ICON_H + BAR_H);

    always_comb begin
        sel_hit  = 1'b0;
        sel_slot = '0;
        sel_dx   = '0;
        for (int i = NUM_ORDERS - 1; i >= 0; i--) begin
            if (x_hit[i]) begin
                sel_hit  = 1'b1;
                sel_slot = SLOT_W'(i);
                sel_dx   = dx_all[i];
            end
        end
    end

    // rpipe[0] is stage 0; the rest ride alongside the ROM read.
    rflag_t          rpipe [ROM_LATENCY+1];
    logic [DY_W-1:0] s0_dy;

    assign rom_addr_out = ROM_AW'(slot_type[rpipe[0].slot]) * ROM_AW'(ICON_W * ICON_H)
                        + ROM_AW'(s0_dy) * ROM_AW'(ICON_W) + ROM_AW'(rpipe[0].dx);

    rflag_t             fin;
    logic [TIMER_W-1:0] fin_time;
    logic               fin_low;
    logic [11:0]        pix_next;

    assign fin      = rpipe[ROM_LATENCY];
    assign fin_time = slot_time[fin.slot];
    assign fin_low  = int'(fin_time) <= BLINK_THRESH;

    always_comb begin
        pix_next = C_NONE;
        if (fin.icon || fin.bar) begin
            if (!ord.active_mask[fin.slot])        pix_next = C_EMPTY;
            else if (fin.icon)                     pix_next = (fin_low && blink_phase) ? C_BLINK : rom_pixel_in;
            else if (int'(fin.dx) < int'(fin_time)) pix_next = C_BAR_OK;
            else if (fin_low)                      pix_next = C_BAR_LOW;
            else                                   pix_next = C_BAR_BG;
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int k = 0; k <= ROM_LATENCY; k++) rpipe[k] <= '0;
            s0_dy     <= '0;
            pixel_out <= C_NONE;
        end else begin
            rpipe[0].icon <= sel_hit && icon_row;
            rpipe[0].bar  <= sel_hit && bar_row;
            rpipe[0].slot <= sel_slot;
            rpipe[0].dx   <= sel_dx;
            s0_dy         <= DY_W'(ry);
            for (int k = 1; k <= ROM_LATENCY; k++) rpipe[k] <= rpipe[k-1];
            pixel_out     <= pix_next;
        end
    end
endmodule
